// File: rtl/trigger_conditioner.sv
// Trigger front-end: synchronises and debounces a raw pin, emits a clean level with
// rise/fall pulses, and captures mode/weight configuration on each qualified edge.
module trigger_conditioner #(
  parameter int unsigned WEIGHT_BIT_WIDTH = 8,
  parameter int unsigned DEBOUNCE_WIDTH   = 8,
  parameter int unsigned SYNC_STAGES      = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        trig_raw,
  input  logic [DEBOUNCE_WIDTH-1:0]   debounce_cycles,
  input  logic                        mode_a_in,
  input  logic                        mode_b_in,
  input  logic [WEIGHT_BIT_WIDTH-1:0] weight_in,
  input  logic                        glitch_clr,
  output logic                        trigger_out,
  output logic                        trigger_rise,
  output logic                        trigger_fall,
  output logic                        mode_a,
  output logic                        mode_b,
  output logic [WEIGHT_BIT_WIDTH-1:0] weighted_bits,
  output logic [7:0]                  glitch_cnt
);

  typedef enum logic [1:0] {StLow, StQualH, StHigh, StQualL} state_e;

  state_e                      state_q, state_d;
  logic [SYNC_STAGES-1:0]      sync_chain_q;
  logic                        trig_sync;
  logic [DEBOUNCE_WIDTH-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [DEBOUNCE_WIDTH-1:0]   n_q, n_d, n_eff;
  logic                        qual_rise, qual_fall, glitch;
  logic                        trigger_out_q, trigger_rise_q, trigger_fall_q;
  logic                        mode_a_q, mode_b_q;
  logic [WEIGHT_BIT_WIDTH-1:0] weight_q;
  logic [7:0]                  glitch_cnt_q, glitch_cnt_d;

  assign trig_sync = sync_chain_q[SYNC_STAGES-1];
  assign cnt_inc   = cnt_q + DEBOUNCE_WIDTH'(1);
  assign n_eff     = (debounce_cycles == '0) ? DEBOUNCE_WIDTH'(1) : debounce_cycles;

  // Qualification length is frozen while a qualification is in progress.
  assign n_d = (state_q == StLow || state_q == StHigh) ? n_eff : n_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    qual_rise = 1'b0;
    qual_fall = 1'b0;
    glitch    = 1'b0;
    unique case (state_q)
      StLow: begin
        if (trig_sync) begin
          if (n_q == DEBOUNCE_WIDTH'(1)) begin
            state_d   = StHigh;
            qual_rise = 1'b1;
            cnt_d     = '0;
          end else begin
            state_d = StQualH;
            cnt_d   = DEBOUNCE_WIDTH'(1);
          end
        end
      end
      StQualH: begin
        if (!trig_sync) begin
          state_d = StLow;
          glitch  = 1'b1;
          cnt_d   = '0;
        end else if (cnt_inc == n_q) begin
          state_d   = StHigh;
          qual_rise = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StHigh: begin
        if (!trig_sync) begin
          if (n_q == DEBOUNCE_WIDTH'(1)) begin
            state_d   = StLow;
            qual_fall = 1'b1;
            cnt_d     = '0;
          end else begin
            state_d = StQualL;
            cnt_d   = DEBOUNCE_WIDTH'(1);
          end
        end
      end
      StQualL: begin
        if (trig_sync) begin
          state_d = StHigh;
          glitch  = 1'b1;
          cnt_d   = '0;
        end else if (cnt_inc == n_q) begin
          state_d   = StLow;
          qual_fall = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
    endcase
  end

  // Clear wins over a coincident glitch; count saturates rather than wrapping.
  always_comb begin
    glitch_cnt_d = glitch_cnt_q;
    if (glitch_clr) begin
      glitch_cnt_d = '0;
    end else if (glitch && glitch_cnt_q != 8'hFF) begin
      glitch_cnt_d = glitch_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_chain_q   <= '0;
      state_q        <= StLow;
      cnt_q          <= '0;
      n_q            <= DEBOUNCE_WIDTH'(1);
      trigger_out_q  <= 1'b0;
      trigger_rise_q <= 1'b0;
      trigger_fall_q <= 1'b0;
      mode_a_q       <= 1'b0;
      mode_b_q       <= 1'b0;
      weight_q       <= '0;
      glitch_cnt_q   <= '0;
    end else begin
      sync_chain_q   <= {sync_chain_q[SYNC_STAGES-2:0], trig_raw};
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      n_q            <= n_d;
      trigger_rise_q <= qual_rise;
      trigger_fall_q <= qual_fall;
      glitch_cnt_q   <= glitch_cnt_d;
      if (qual_rise || qual_fall) begin
        trigger_out_q <= qual_rise;
        mode_a_q      <= mode_a_in;
        mode_b_q      <= mode_b_in;
        weight_q      <= weight_in;
      end
    end
  end

  assign trigger_out   = trigger_out_q;
  assign trigger_rise  = trigger_rise_q;
  assign trigger_fall  = trigger_fall_q;
  assign mode_a        = mode_a_q;
  assign mode_b        = mode_b_q;
  assign weighted_bits = weight_q;
  assign glitch_cnt    = glitch_cnt_q;

endmodule

// File: tb/tb_trigger_conditioner.sv
// Directed bench for trigger_conditioner: a table of hold-and-check vectors plus
// hand-written sequences for mid-qualification reconfiguration, glitch saturation and reset.
module tb_trigger_conditioner;

  logic       clk = 1'b0;
  logic       rst;
  logic       trig_raw;
  logic [7:0] debounce_cycles;
  logic       mode_a_in, mode_b_in;
  logic [7:0] weight_in;
  logic       glitch_clr;
  logic       trigger_out, trigger_rise, trigger_fall;
  logic       mode_a, mode_b;
  logic [7:0] weighted_bits;
  logic [7:0] glitch_cnt;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  trigger_conditioner #(
    .WEIGHT_BIT_WIDTH(8),
    .DEBOUNCE_WIDTH  (8),
    .SYNC_STAGES     (2)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .trig_raw       (trig_raw),
    .debounce_cycles(debounce_cycles),
    .mode_a_in      (mode_a_in),
    .mode_b_in      (mode_b_in),
    .weight_in      (weight_in),
    .glitch_clr     (glitch_clr),
    .trigger_out    (trigger_out),
    .trigger_rise   (trigger_rise),
    .trigger_fall   (trigger_fall),
    .mode_a         (mode_a),
    .mode_b         (mode_b),
    .weighted_bits  (weighted_bits),
    .glitch_cnt     (glitch_cnt)
  );

  typedef struct {
    logic       raw;
    logic [7:0] db;
    logic       ma, mb;
    logic [7:0] w;
    logic       clr;
    int         cyc;
    logic       eo, er, ef, ema, emb;
    logic [7:0] ew, eg;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic raw, input logic [7:0] db, input logic ma, input logic mb,
                     input logic [7:0] w, input logic clr, input int cyc,
                     input logic eo, input logic er, input logic ef, input logic ema,
                     input logic emb, input logic [7:0] ew, input logic [7:0] eg);
    vec_t v;
    v = '{raw, db, ma, mb, w, clr, cyc, eo, er, ef, ema, emb, ew, eg};
    vecs.push_back(v);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [20:0] outs();
    return {trigger_out, trigger_rise, trigger_fall, mode_a, mode_b, weighted_bits, glitch_cnt};
  endfunction

  task automatic check(input string name, input logic [20:0] req);
    logic [20:0] act;
    act = outs();
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s: got out/rise/fall/ma/mb/w/g=%b/%b/%b/%b/%b/%h/%0d required %b/%b/%b/%b/%b/%h/%0d",
               name, act[20], act[19], act[18], act[17], act[16], act[15:8], act[7:0],
               req[20], req[19], req[18], req[17], req[16], req[15:8], req[7:0]);
    end
  endtask

  initial begin
    // raw db ma mb w clr cyc | out rise fall ma mb w g
    add(0, 4, 0, 0, 8'h00, 0, 2,  0, 0, 0, 0, 0, 8'h00, 0);
    add(1, 4, 1, 0, 8'h2A, 0, 5,  0, 0, 0, 0, 0, 8'h00, 0);
    add(1, 4, 1, 0, 8'h2A, 0, 1,  1, 1, 0, 1, 0, 8'h2A, 0);
    add(1, 4, 1, 0, 8'h2A, 0, 1,  1, 0, 0, 1, 0, 8'h2A, 0);
    add(0, 4, 0, 1, 8'h11, 0, 5,  1, 0, 0, 1, 0, 8'h2A, 0);
    add(0, 4, 0, 1, 8'h11, 0, 1,  0, 0, 1, 0, 1, 8'h11, 0);
    add(0, 4, 0, 1, 8'h11, 0, 1,  0, 0, 0, 0, 1, 8'h11, 0);
    add(1, 4, 0, 1, 8'h11, 0, 2,  0, 0, 0, 0, 1, 8'h11, 0);
    add(0, 4, 0, 1, 8'h11, 0, 3,  0, 0, 0, 0, 1, 8'h11, 1);
    add(0, 4, 0, 1, 8'h11, 0, 3,  0, 0, 0, 0, 1, 8'h11, 1);
    add(1, 4, 1, 1, 8'hC3, 0, 6,  1, 1, 0, 1, 1, 8'hC3, 1);
    add(0, 4, 0, 0, 8'h55, 0, 2,  1, 0, 0, 1, 1, 8'hC3, 1);
    add(1, 4, 0, 0, 8'h55, 0, 3,  1, 0, 0, 1, 1, 8'hC3, 2);
    add(1, 4, 0, 0, 8'h55, 0, 3,  1, 0, 0, 1, 1, 8'hC3, 2);
    add(0, 1, 0, 1, 8'h01, 0, 2,  1, 0, 0, 1, 1, 8'hC3, 2);
    add(0, 1, 0, 1, 8'h01, 0, 1,  0, 0, 1, 0, 1, 8'h01, 2);
    add(1, 0, 1, 0, 8'h02, 0, 2,  0, 0, 0, 0, 1, 8'h01, 2);
    add(1, 0, 1, 0, 8'h02, 0, 1,  1, 1, 0, 1, 0, 8'h02, 2);
    add(0, 0, 0, 0, 8'h03, 0, 1,  1, 0, 0, 1, 0, 8'h02, 2);
    add(1, 0, 0, 0, 8'h03, 0, 1,  1, 0, 0, 1, 0, 8'h02, 2);
    add(1, 0, 0, 0, 8'h03, 0, 1,  0, 0, 1, 0, 0, 8'h03, 2);
    add(1, 0, 0, 0, 8'h03, 0, 1,  1, 1, 0, 0, 0, 8'h03, 2);
    add(1, 4, 0, 0, 8'h03, 0, 3,  1, 0, 0, 0, 0, 8'h03, 2);
    add(1, 4, 0, 0, 8'h03, 1, 1,  1, 0, 0, 0, 0, 8'h03, 0);
    add(1, 4, 0, 0, 8'h03, 0, 1,  1, 0, 0, 0, 0, 8'h03, 0);

    rst = 1'b1; trig_raw = 1'b0; debounce_cycles = 8'd4;
    mode_a_in = 1'b0; mode_b_in = 1'b0; weight_in = 8'h00; glitch_clr = 1'b0;
    tick(3);
    check("reset_state", 21'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      trig_raw        = vecs[i].raw;
      debounce_cycles = vecs[i].db;
      mode_a_in       = vecs[i].ma;
      mode_b_in       = vecs[i].mb;
      weight_in       = vecs[i].w;
      glitch_clr      = vecs[i].clr;
      tick(vecs[i].cyc);
      check($sformatf("vec%0d", i), {vecs[i].eo, vecs[i].er, vecs[i].ef, vecs[i].ema,
                                      vecs[i].emb, vecs[i].ew, vecs[i].eg});
    end

    // Fall from HIGH, then debounce change 4->8 while qualifying high still qualifies at 4.
    trig_raw = 1'b0;
    tick(6);
    check("fall_n4", {3'b001, 2'b00, 8'h03, 8'd0});
    tick(2);
    mode_a_in = 1'b1; mode_b_in = 1'b1; weight_in = 8'h44; trig_raw = 1'b1;
    tick(3);
    debounce_cycles = 8'd8;
    tick(2);
    check("midq_not_yet", {3'b000, 2'b00, 8'h03, 8'd0});
    tick(1);
    check("midq_rise_at_4", {3'b110, 2'b11, 8'h44, 8'd0});
    debounce_cycles = 8'd4;
    tick(2);
    trig_raw = 1'b0;
    tick(6);
    check("fall_after_midq", {3'b001, 2'b11, 8'h44, 8'd0});
    tick(2);

    // 300 rejected one-cycle pulses saturate the glitch counter.
    for (int k = 0; k < 300; k++) begin
      trig_raw = 1'b1;
      tick(1);
      trig_raw = 1'b0;
      tick(3);
    end
    check("glitch_sat", {3'b000, 2'b11, 8'h44, 8'd255});
    trig_raw = 1'b1;
    tick(1);
    trig_raw = 1'b0;
    tick(2);
    glitch_clr = 1'b1;
    tick(1);
    glitch_clr = 1'b0;
    check("clr_beats_glitch", {3'b000, 2'b11, 8'h44, 8'd0});
    trig_raw = 1'b1;
    tick(1);
    trig_raw = 1'b0;
    tick(3);
    check("glitch_after_clr", {3'b000, 2'b11, 8'h44, 8'd1});

    // Reset while HIGH: outputs clear with no fall pulse, then a normal rise.
    mode_a_in = 1'b1; mode_b_in = 1'b0; weight_in = 8'h5A; trig_raw = 1'b1;
    tick(6);
    check("rise_before_rst", {3'b110, 2'b10, 8'h5A, 8'd1});
    tick(2);
    rst = 1'b1;
    tick(1);
    check("rst_in_high", 21'd0);
    rst = 1'b0;
    tick(5);
    check("post_rst_wait", 21'd0);
    tick(1);
    check("post_rst_rise", {3'b110, 2'b10, 8'h5A, 8'd0});
    tick(1);
    check("post_rst_hold", {3'b100, 2'b10, 8'h5A, 8'd0});

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
